ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the same open-drain PS2Clk/PS2Data lines the PS/2 receiver listens on. It runs the full host request-to-send sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop, and device ACK. It reports completion and error. It sits beside the receiver in the keyboard top level, and the top level converts its output-enables into tristate drivers.

## Interface
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- INHIBIT_US, 100, clock-inhibit time before the request-to-send.
- TIMEOUT_US, 15000, maximum gap between successive device clock falling edges, and from request to first edge.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to send `din`; honoured only while `ready`=1.
- din  in  8  command byte, latched on an accepted `start`.
- ready  out  1  high in IDLE only; low means this block owns the bus.
- done  out  1  one-cycle pulse at the end of every transaction, including on error.
- err  out  1  valid with `done`: 1 = NACK or timeout, 0 = ACKed.
- ps2_clk_i  in  1  raw PS2Clk line level (asynchronous).
- ps2_data_i  in  1  raw PS2Data line level (asynchronous).
- ps2_clk_oe  out  1  1 = drive PS2Clk low, 0 = release (high-Z).
- ps2_data_oe  out  1  1 = drive PS2Data low, 0 = release.

## Operation
- Both line inputs pass through a 2-FF synchronizer; `fall` = one-cycle pulse on a synchronized 1→0 of the clock line.
- N_INH = CLK_FREQ_HZ/1_000_000*INHIBIT_US. N_TO = CLK_FREQ_HZ/1_000_000*TIMEOUT_US. Counter widths come from $clog2 of the larger value.
- Shift word = {stop=1, parity=~^din, din}, 10 bits, shifted out LSB first. The start bit is driven separately.
- IDLE: both oe=0, ready=1. On start: latch word, go to INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0 for N_INH cycles, then REQ.
- REQ: clk_oe=1, data_oe=1 (start bit) for 16 cycles, then DATA.
- DATA: clk_oe=0. data_oe = ~current bit. The start bit is held until the first `fall`. On each `fall`, present the next shift bit, bit counter +1. Falls 1–8 present data bits, fall 9 presents parity, and fall 10 presents stop (data_oe=0). Go to ACK after fall 10.
- ACK: both oe=0. On the next `fall`, sample synchronized data: 0 = ACK, 1 = NACK. Record the result and go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronized clk=1 and data=1, then DONE.
- DONE: pulse done with err = recorded NACK, go to IDLE.
- Watchdog: counts in DATA, ACK, and WAIT_IDLE. It clears on entry and on every `fall`. Reaching N_TO releases both oe, pulses done with err=1, and returns to IDLE. The state passes through DONE with a forced error.
- `start` while ready=0 is ignored, and `din` is not re-latched.
- Receiver output during ready=0 is undefined; integrating logic ignores it until `done`.

## Timing
- Reset (async): state=IDLE, ready=1, done=0, err=0, ps2_clk_oe=0, ps2_data_oe=0, counters=0. Asserting reset mid-frame releases both lines immediately.
- The start-accept cycle is followed by clk_oe=1 from the next cycle, for exactly N_INH cycles. data_oe rises on the first REQ cycle. clk_oe falls 16 cycles later.
- Input synchronization delay is 2 cycles. A data bit changes 1 cycle after the synchronized `fall`, well within the device's half-period.
- done follows WAIT_IDLE exit by 1 cycle, and ready=1 the cycle after done.
- err is held between done pulses. It is updated only at done.

## Structure
- Package `ps2_pkg`:
  - state enum: IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE, DONE.
  - command constants: CMD_SET_LED=8'hED, CMD_ECHO=8'hEE, CMD_RESET=8'hFF.
  - response constant: RSP_ACK=8'hFA.
- Sub-module `ps2_sync_edge`: 2-FF synchronizers for both lines plus the falling-edge detector. The receiver can share it.
- Top-level tristates: PS2Clk = ps2_clk_oe ? 0 : z, and likewise for PS2Data.

## Test plan
Bench parameters: CLK_FREQ_HZ=1_000_000, INHIBIT_US=100 (N_INH=100), TIMEOUT_US=500. The device model runs a 20-cycle PS/2 clock period.
- Send 0xED with the device ACKing. The device samples start=0, then bits 1,0,1,1,0,1,1,1, parity=1, stop=1. done=1 with err=0.
- Send 0x01 (parity 0), then 0xFF (parity 1), with the device ACKing. Both parity bits are correct and err=0.
- Device leaves data high at the ACK edge: done=1 with err=1, and the block returns to ready.
- Device never clocks after REQ: done+err exactly 500 cycles after entering DATA, with both oe=0.
- clk_oe is high for exactly 100 cycles, then data_oe rises. A start pulse during DATA is ignored and the byte is unchanged.
- Assert rst at data bit 4: both oe=0 in the same cycle, ready=1 after release, and the next 0xEE send completes with err=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_IDLE,
        DONE
    } state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // Start bit is held low for this many cycles before the clock is released.
    localparam int REQ_CYCLES = 16;
    // Bits clocked out after the start bit: 8 data, parity, stop.
    localparam int FRAME_BITS = 10;

    // Shift word sent LSB first: {stop, odd parity, data}.
    function automatic logic [9:0] make_word(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for PS2Clk/PS2Data plus a PS2Clk falling-edge pulse.
// Latency: 2 cycles line-to-synchronized level; fall pulses on the 3rd cycle.
// Backpressure: none; free-running sampler.
module ps2_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_s,
    output logic o_data_s,
    output logic o_fall
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;

    // Sync chains reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign o_clk_s  = r_clk_sync[1];
    assign o_data_s = r_data_sync[1];
    assign o_fall   = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (inhibit, request-to-send, frame, ACK).
// Latency: N_INH + 16 cycles to release the clock, then device-paced; done 1 cycle after bus idle.
// Backpressure: start accepted only while ready=1; otherwise ignored and din not re-latched.
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 15000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       ready,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    import ps2_pkg::*;

    localparam int N_INH = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int N_TO  = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int N_BIG = (N_INH > N_TO) ? N_INH : N_TO;
    localparam int CW    = $clog2((N_BIG > REQ_CYCLES) ? N_BIG : REQ_CYCLES);

    localparam logic [CW-1:0] INH_LAST = CW'(N_INH - 1);
    localparam logic [CW-1:0] REQ_LAST = CW'(REQ_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(N_TO - 1);
    localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [9:0]    r_word;
    logic [3:0]    r_bitcnt;
    logic          r_cur;
    logic          r_nack;
    logic          r_err;
    logic          w_clk_s;
    logic          w_data_s;
    logic          w_fall;
    logic          w_watch;
    logic          w_timeout;
    logic          w_clk_oe;
    logic          w_data_oe;
    logic          w_ready;
    logic          w_done;

    ps2_sync_edge u_sync (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ps2_clk  (ps2_clk_i),
        .i_ps2_data (ps2_data_i),
        .o_clk_s    (w_clk_s),
        .o_data_s   (w_data_s),
        .o_fall     (w_fall)
    );

    // State register; async reset drops both line drivers immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and line/handshake outputs; watchdog expiry forces DONE with error.
    always_comb begin
        w_state_nxt = r_state;
        w_watch     = 1'b0;
        w_timeout   = 1'b0;
        w_clk_oe    = 1'b0;
        w_data_oe   = 1'b0;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (start) w_state_nxt = INHIBIT;
            end
            INHIBIT: begin
                w_clk_oe = 1'b1;
                if (r_cnt == INH_LAST) w_state_nxt = REQ;
            end
            REQ: begin
                w_clk_oe  = 1'b1;
                w_data_oe = 1'b1;
                if (r_cnt == REQ_LAST) w_state_nxt = DATA;
            end
            DATA: begin
                w_watch   = 1'b1;
                w_data_oe = ~r_cur;
                if (w_fall) begin
                    if (r_bitcnt == BIT_LAST) w_state_nxt = ACK;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            ACK: begin
                w_watch = 1'b1;
                if (w_fall) begin
                    w_state_nxt = WAIT_IDLE;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            WAIT_IDLE: begin
                w_watch = 1'b1;
                if (w_clk_s && w_data_s) begin
                    w_state_nxt = DONE;
                end else if (!w_fall && r_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Phase timer / watchdog: restarts on every state change and on device clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state || r_state == IDLE || (w_watch && w_fall)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Frame datapath: latch word on accept, shift one bit per device falling edge, capture ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word   <= '0;
            r_bitcnt <= '0;
            r_cur    <= 1'b0;
            r_nack   <= 1'b0;
        end else begin
            if (r_state == IDLE && start) r_word <= make_word(din);
            if (r_state == REQ) begin
                r_bitcnt <= '0;
                r_cur    <= 1'b0;
            end else if (r_state == DATA && w_fall) begin
                r_cur    <= r_word[0];
                r_word   <= {1'b0, r_word[9:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
            end
            if (r_state == ACK && w_fall) r_nack <= w_data_s;
        end
    end

    // Result flag changes only as DONE is entered, so it stays valid between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else if (w_state_nxt == DONE && r_state != DONE) r_err <= w_timeout | r_nack;
    end

    assign ready       = w_ready;
    assign done        = w_done;
    assign err         = r_err;
    assign ps2_clk_oe  = w_clk_oe;
    assign ps2_data_oe = w_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed plus randomized bench for ps2_host_tx with an open-drain PS/2 device model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_host_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       ready;
    logic       done;
    logic       err;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk_low;
    logic       dev_data_low;

    int total;
    int bad;
    logic last_err;

    ps2_host_tx #(
        .CLK_FREQ_HZ (1_000_000),
        .INHIBIT_US  (100),
        .TIMEOUT_US  (500)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .din         (din),
        .ready       (ready),
        .done        (done),
        .err         (err),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    // Wired-AND bus: either side may pull a line low.
    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bits the device should see: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic do_start(input logic [7:0] b);
        chk("ready_idle", 32'(ready), 32'd1);
        chk("err_hold", 32'(err), 32'(last_err));
        start = 1'b1;
        din   = b;
        tick();
        start = 1'b0;
        din   = 8'($urandom);
    endtask

    task automatic phase_check();
        int n;
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 1000) begin
            n++;
            tick();
        end
        chk("inhibit_len", 32'(n), 32'd100);
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && n < 1000) begin
            n++;
            tick();
        end
        chk("req_len", 32'(n), 32'd16);
        chk("data_entry_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
    endtask

    // One device clock period: 10 high (sample near the end), 10 low.
    task automatic dev_pulse(input bit pull_ack, output logic s);
        repeat (8) tick();
        s = ps2_data_i;
        if (pull_ack) dev_data_low = 1'b1;
        repeat (2) tick();
        dev_clk_low = 1'b1;
        repeat (10) tick();
        dev_clk_low = 1'b0;
    endtask

    task automatic device_frame(input bit ack, input bit poke, output logic [10:0] got);
        logic s;
        got = '0;
        for (int i = 0; i < 11; i++) begin
            if (poke && i == 3) begin
                chk("busy_not_ready", 32'(ready), 32'd0);
                start = 1'b1;
                din   = 8'h3C;
                tick();
                start = 1'b0;
            end
            dev_pulse(ack && i == 10, s);
            got[i] = s;
        end
        if (ack) begin
            repeat (5) tick();
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_done(input bit exp_err);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("err_at_done", 32'(err), 32'(exp_err));
        last_err = exp_err;
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("ready_after", 32'(ready), 32'd1);
    endtask

    task automatic xfer(input logic [7:0] b, input bit ack, input bit poke);
        logic [10:0] got;
        do_start(b);
        phase_check();
        device_frame(ack, poke, got);
        chk("frame_bits", 32'(got), 32'(exp_frame(b)));
        wait_done(!ack);
    endtask

    initial begin
        logic s;
        int   n;
        total        = 0;
        bad          = 0;
        last_err     = 1'b0;
        rst          = 1'b1;
        start        = 1'b0;
        din          = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) tick();

        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b00);
        rst = 1'b0;
        tick();

        // Command bytes with ACK, parity both ways.
        xfer(ps2_pkg::CMD_SET_LED, 1'b1, 1'b0);
        xfer(8'h01, 1'b1, 1'b0);
        xfer(ps2_pkg::CMD_RESET, 1'b1, 1'b0);

        // Device NACKs.
        xfer(ps2_pkg::CMD_SET_LED, 1'b0, 1'b0);

        // Device never clocks: watchdog ends the transfer 500 cycles into DATA.
        do_start(8'h55);
        phase_check();
        n = 0;
        while (done !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd500);
        chk("timeout_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b00);
        wait_done(1'b1);

        // Start during DATA is ignored; byte on the wire unchanged.
        xfer(8'hA5, 1'b1, 1'b1);
        chk("no_relaunch", 32'(ps2_clk_oe), 32'd0);

        // Reset while data bit 4 (a 0) is being driven.
        do_start(8'h0F);
        phase_check();
        for (int i = 0; i < 5; i++) dev_pulse(1'b0, s);
        repeat (8) tick();
        chk("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b00);
        tick();
        rst = 1'b0;
        tick();
        last_err = 1'b0;
        chk("rst_mid_ready", 32'(ready), 32'd1);
        xfer(ps2_pkg::CMD_ECHO, 1'b1, 1'b0);

        // Random bytes and random device response.
        for (int r = 0; r < 6; r++) begin
            xfer(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
